// File: rtl/aes_sbox_sched_pkg.sv
// Shared types and helpers for the masked S-box scheduler.
//   state_t     : scheduler FSM states
//   job_t       : which requester owns the S-box (key or state)
//   stage_t     : captured masked S-box result plus the masks used for it
//   unmask_vec  : maps the two mask bits to the 8-bit output mask of the S-box
package aes_sbox_sched_pkg;

    localparam int ST_BYTES_DEF  = 16;
    localparam int KEY_BYTES_DEF = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef enum logic {JOB_KEY, JOB_STATE} job_t;

    typedef struct packed {
        logic [7:0] out;
        logic       m1;
        logic       m2;
    } stage_t;

    // Output mask the S-box applies for a given (MASK1, MASK2) pair.
    function automatic logic [7:0] unmask_vec(input logic m1, input logic m2);
        return {1'b0, m2, m1, m1 ^ m2, m2, m1, 1'b0, m1 ^ m2};
    endfunction

endpackage

// File: rtl/aes_sbox_sched_arb.sv
// Request arbiter for the S-box scheduler, evaluated while the FSM is idle.
//   clk, rst        : clock, async active-high reset
//   idle            : FSM is in IDLE (a grant is taken when any_req is high)
//   st_req, key_req : level requests
//   any_req         : at least one request pending
//   grant           : selected job type
// Build option SBOX_RR_ARB_EN: round-robin between the two requesters;
// otherwise the key requester always wins.
module aes_sbox_sched_arb
    import aes_sbox_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic st_req,
    input  logic key_req,
    output logic any_req,
    output job_t grant
);

    assign any_req = st_req | key_req;

`ifdef SBOX_RR_ARB_EN
    // 1 = the state requester was served last; starts at 1 so key goes first.
    logic last_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_st <= 1'b1;
        else if (idle && any_req)
            last_st <= (grant == JOB_STATE);
    end

    always_comb begin
        grant = JOB_KEY;
        if (st_req && key_req)
            grant = last_st ? JOB_KEY : JOB_STATE;
        else if (st_req)
            grant = JOB_STATE;
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst, idle};
    assign grant      = key_req ? JOB_KEY : JOB_STATE;
`endif

endmodule

// File: rtl/aes_sbox_sched.sv
// Time-multiplexes one external masked AES S-box between a state requester
// (SubBytes, ST_BYTES bytes) and a key requester (SubWord, KEY_BYTES bytes).
// Each byte is driven with fresh masks, the masked result is captured in a
// one-deep stage and unmasked into the result register of the running job.
// Ports:
//   clk, rst                   : clock, async active-high reset
//   st_req/st_data             : state job request (level) and operand
//   st_ack/st_done/st_res      : accept pulse, done pulse, SubBytes result
//   key_req/key_data           : key job request (level) and operand
//   key_ack/key_done/key_res   : accept pulse, done pulse, SubWord result
//   rnd                        : fresh random bits, rnd[0]=MASK1, rnd[1]=MASK2
//   sbox_in/sbox_m1/sbox_m2    : operand and masks to the S-box
//   sbox_out                   : masked S-box output (combinational)
// Build option SBOX_RR_ARB_EN selects round-robin arbitration (see arbiter).
module aes_sbox_sched
    import aes_sbox_sched_pkg::*;
#(
    parameter int ST_BYTES  = ST_BYTES_DEF,
    parameter int KEY_BYTES = KEY_BYTES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_req,
    input  logic [8*ST_BYTES-1:0]   st_data,
    output logic                    st_ack,
    output logic                    st_done,
    output logic [8*ST_BYTES-1:0]   st_res,
    input  logic                    key_req,
    input  logic [8*KEY_BYTES-1:0]  key_data,
    output logic                    key_ack,
    output logic                    key_done,
    output logic [8*KEY_BYTES-1:0]  key_res,
    input  logic [1:0]              rnd,
    output logic [7:0]              sbox_in,
    output logic                    sbox_m1,
    output logic                    sbox_m2,
    input  logic [7:0]              sbox_out
);

    localparam int CNT_W  = $clog2(ST_BYTES);
    localparam int KIDX_W = $clog2(KEY_BYTES);
    localparam int OPND_W = 8 * ST_BYTES;

    state_t                         state, state_nxt;
    job_t                           job, grant;
    logic                           any_req, accept, last_byte;
    logic [CNT_W-1:0]               cnt;
    logic [ST_BYTES-1:0][7:0]       opnd;
    logic                           stg_vld;
    stage_t                         stg;
    logic [CNT_W-1:0]               stg_idx;
    logic [ST_BYTES-1:0][7:0]       st_res_q;
    logic [KEY_BYTES-1:0][7:0]      key_res_q;
    logic                           st_ack_q, key_ack_q;
    logic [7:0]                     wb_byte;

    aes_sbox_sched_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .idle    (state == IDLE),
        .st_req  (st_req),
        .key_req (key_req),
        .any_req (any_req),
        .grant   (grant)
    );

    assign accept    = (state == IDLE) && any_req;
    assign last_byte = cnt == ((job == JOB_KEY) ? CNT_W'(KEY_BYTES - 1)
                                                : CNT_W'(ST_BYTES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = RUN;
            RUN:     if (last_byte) state_nxt = FLUSH;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- S-box drive ----------------
    // Masks pass straight through so the S-box sees this cycle's fresh bits.
    assign sbox_in = (state == RUN) ? opnd[cnt] : 8'h00;
    assign sbox_m1 = (state == RUN) & rnd[0];
    assign sbox_m2 = (state == RUN) & rnd[1];

    assign wb_byte = stg.out ^ unmask_vec(stg.m1, stg.m2);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job       <= JOB_KEY;
            cnt       <= '0;
            opnd      <= '0;
            stg_vld   <= 1'b0;
            stg       <= '0;
            stg_idx   <= '0;
            st_res_q  <= '0;
            key_res_q <= '0;
            st_ack_q  <= 1'b0;
            key_ack_q <= 1'b0;
        end else begin
            st_ack_q  <= accept && (grant == JOB_STATE);
            key_ack_q <= accept && (grant == JOB_KEY);

            stg_vld <= (state == RUN);
            if (state == RUN) begin
                stg     <= '{out: sbox_out, m1: sbox_m1, m2: sbox_m2};
                stg_idx <= cnt;
            end

            if (accept) begin
                job <= grant;
                cnt <= '0;
                if (grant == JOB_KEY)
                    opnd <= OPND_W'(key_data);
                else
                    opnd <= st_data;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Only the running job's result register is ever written.
            if (stg_vld) begin
                if (job == JOB_STATE)
                    st_res_q[stg_idx] <= wb_byte;
                else
                    key_res_q[stg_idx[KIDX_W-1:0]] <= wb_byte;
            end
        end
    end

    assign st_ack   = st_ack_q;
    assign key_ack  = key_ack_q;
    assign st_done  = (state == DONE) && (job == JOB_STATE);
    assign key_done = (state == DONE) && (job == JOB_KEY);
    assign st_res   = st_res_q;
    assign key_res  = key_res_q;

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Directed bench for aes_sbox_sched with a behavioural masked S-box attached.
module tb_aes_sbox_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_req = 1'b0;
    logic [127:0] st_data = '0;
    logic         st_ack, st_done;
    logic [127:0] st_res;
    logic         key_req = 1'b0;
    logic [31:0]  key_data = '0;
    logic         key_ack, key_done;
    logic [31:0]  key_res;
    logic [1:0]   rnd = 2'b00;
    logic [7:0]   sbox_in;
    logic         sbox_m1, sbox_m2;
    logic [7:0]   sbox_out;

    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    bit  rnd_hold = 1'b0;
    logic [1:0] rnd_val = 2'b00;

    aes_sbox_sched dut (
        .clk(clk), .rst(rst),
        .st_req(st_req), .st_data(st_data), .st_ack(st_ack), .st_done(st_done), .st_res(st_res),
        .key_req(key_req), .key_data(key_data), .key_ack(key_ack), .key_done(key_done), .key_res(key_res),
        .rnd(rnd), .sbox_in(sbox_in), .sbox_m1(sbox_m1), .sbox_m2(sbox_m2), .sbox_out(sbox_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always begin
        @(posedge clk);
        #2;
        rnd = rnd_hold ? rnd_val : 2'($urandom_range(0, 3));
    end

    // ---------------- masked S-box model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        sbox_out = ref_sbox(sbox_in) ^ (sbox_m1 ? 8'h35 : 8'h00) ^ (sbox_m2 ? 8'h59 : 8'h00);
    end

    // ---------------- stimulus helpers ----------------
    // which: 0 st_ack, 1 st_done, 2 key_ack, 3 key_done. at = cycle seen, -1 on timeout.
    task automatic wait_sig(input int which, input int budget, output int at);
        logic s;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            case (which)
                0: s = st_ack;
                1: s = st_done;
                2: s = key_ack;
                default: s = key_done;
            endcase
            if (s) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({st_ack, st_done, key_ack, key_done, sbox_in, sbox_m1, sbox_m2} !== 14'h0)
            $display("FAIL reset_ctrl: got %h expected 0", {st_ack, st_done, key_ack, key_done, sbox_in, sbox_m1, sbox_m2});
        else n_pass++;
        n_chk++;
        if (st_res !== 128'h0) $display("FAIL reset_st_res: got %h expected 0", st_res);
        else n_pass++;
        n_chk++;
        if (key_res !== 32'h0) $display("FAIL reset_key_res: got %h expected 0", key_res);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_state_zero();
        int t0, a, d;
        @(posedge clk);
        #1;
        t0 = cyc;
        st_data = '0;
        st_req  = 1'b1;
        wait_sig(0, 5, a);
        st_req = 1'b0;
        n_chk++;
        if (a - t0 !== 1) $display("FAIL st_ack_cycle: got %0d expected 1", a - t0);
        else n_pass++;
        wait_sig(1, 40, d);
        n_chk++;
        if (d - t0 !== 18) $display("FAIL st_done_cycle: got %0d expected 18", d - t0);
        else n_pass++;
        n_chk++;
        if (st_res !== {16{8'h63}}) $display("FAIL st_res_zero: got %h expected %h", st_res, {16{8'h63}});
        else n_pass++;
        n_chk++;
        if ({sbox_in, sbox_m1, sbox_m2} !== 10'h0)
            $display("FAIL sbox_idle_zero: got %h expected 0", {sbox_in, sbox_m1, sbox_m2});
        else n_pass++;
        @(posedge clk);
        #1;
        n_chk++;
        if (st_done !== 1'b0) $display("FAIL st_done_pulse: got %b expected 0", st_done);
        else n_pass++;
    endtask

    task automatic test_key();
        int t0, a, d;
        @(posedge clk);
        #1;
        t0 = cyc;
        key_data = 32'h04030201;
        key_req  = 1'b1;
        wait_sig(2, 5, a);
        key_req = 1'b0;
        n_chk++;
        if (a - t0 !== 1) $display("FAIL key_ack_cycle: got %0d expected 1", a - t0);
        else n_pass++;
        wait_sig(3, 20, d);
        n_chk++;
        if (d - t0 !== 6) $display("FAIL key_done_cycle: got %0d expected 6", d - t0);
        else n_pass++;
        n_chk++;
        if (key_res !== 32'hF27B777C) $display("FAIL key_res: got %h expected F27B777C", key_res);
        else n_pass++;
        n_chk++;
        if (st_res !== {16{8'h63}}) $display("FAIL st_res_untouched: got %h expected %h", st_res, {16{8'h63}});
        else n_pass++;
    endtask

    task automatic test_arb();
        int t0, ka, sa, sd;
        do_reset();
        // pair 1 from reset: key first, state accepted at the edge ending t0+7
        #1;
        t0 = cyc;
        key_data = 32'h04030201;
        st_data  = {4{32'h04030201}};
        key_req  = 1'b1;
        st_req   = 1'b1;
        wait_sig(2, 5, ka);
        key_req = 1'b0;
        wait_sig(0, 20, sa);
        st_req = 1'b0;
        n_chk++;
        if (ka - t0 !== 1) $display("FAIL arb1_key_ack: got %0d expected 1", ka - t0);
        else n_pass++;
        n_chk++;
        if (sa - t0 !== 8) $display("FAIL arb1_st_ack: got %0d expected 8", sa - t0);
        else n_pass++;
        wait_sig(1, 30, sd);
        n_chk++;
        if (sd - t0 !== 25) $display("FAIL arb1_st_done: got %0d expected 25", sd - t0);
        else n_pass++;
        n_chk++;
        if ({st_res, key_res} !== {{4{32'hF27B777C}}, 32'hF27B777C})
            $display("FAIL arb1_results: got %h %h expected %h %h", st_res, key_res, {4{32'hF27B777C}}, 32'hF27B777C);
        else n_pass++;
        // key-only job so the key requester was served last
        @(posedge clk);
        #1 key_req = 1'b1;
        wait_sig(2, 5, ka);
        key_req = 1'b0;
        wait_sig(3, 10, ka);
        // pair 2
        @(posedge clk);
        #1;
        t0 = cyc;
        key_req = 1'b1;
        st_req  = 1'b1;
`ifdef SBOX_RR_ARB_EN
        wait_sig(0, 5, sa);
        st_req = 1'b0;
        wait_sig(2, 30, ka);
        key_req = 1'b0;
        n_chk++;
        if (sa - t0 !== 1) $display("FAIL arb2_st_ack: got %0d expected 1", sa - t0);
        else n_pass++;
        n_chk++;
        if (ka - t0 !== 20) $display("FAIL arb2_key_ack: got %0d expected 20", ka - t0);
        else n_pass++;
        wait_sig(3, 10, ka);
`else
        wait_sig(2, 5, ka);
        key_req = 1'b0;
        wait_sig(0, 20, sa);
        st_req = 1'b0;
        n_chk++;
        if (ka - t0 !== 1) $display("FAIL arb2_key_ack: got %0d expected 1", ka - t0);
        else n_pass++;
        n_chk++;
        if (sa - t0 !== 8) $display("FAIL arb2_st_ack: got %0d expected 8", sa - t0);
        else n_pass++;
        wait_sig(1, 30, sd);
`endif
    endtask

    task automatic test_rnd_sweep();
        int a, d;
        logic [127:0] data;
        data = '0;
        data[47:40] = 8'h53;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            rnd_hold = 1'b1;
            rnd_val  = 2'(r);
            st_data  = data;
            st_req   = 1'b1;
            wait_sig(0, 5, a);
            st_req = 1'b0;
            n_chk++;
            if ({sbox_m2, sbox_m1} !== 2'(r)) $display("FAIL mask_pass_r%0d: got %b expected %b", r, {sbox_m2, sbox_m1}, 2'(r));
            else n_pass++;
            repeat (5) @(posedge clk);
            #1;
            n_chk++;
            if (sbox_in !== 8'h53) $display("FAIL sbox_in_byte5_r%0d: got %h expected 53", r, sbox_in);
            else n_pass++;
            wait_sig(1, 30, d);
            n_chk++;
            if (st_res[47:40] !== 8'hED) $display("FAIL byte5_r%0d: got %h expected ED", r, st_res[47:40]);
            else n_pass++;
        end
        rnd_hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        int a, d, seen;
        @(posedge clk);
        #1;
        st_data = {4{32'h04030201}};
        st_req  = 1'b1;
        wait_sig(0, 5, a);
        st_req = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({st_res, key_res} !== 160'h0) $display("FAIL midrst_results: got %h %h expected 0", st_res, key_res);
        else n_pass++;
        n_chk++;
        if ({st_ack, st_done, sbox_in, sbox_m1, sbox_m2} !== 12'h0)
            $display("FAIL midrst_ctrl: got %h expected 0", {st_ack, st_done, sbox_in, sbox_m1, sbox_m2});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (st_done) seen++;
        end
        n_chk++;
        if (seen !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", seen);
        else n_pass++;
        key_data = 32'h04030201;
        key_req  = 1'b1;
        wait_sig(2, 5, a);
        key_req = 1'b0;
        wait_sig(3, 20, d);
        n_chk++;
        if (d - a !== 5 || key_res !== 32'hF27B777C)
            $display("FAIL midrst_key_job: got done+%0d %h expected done+5 F27B777C", d - a, key_res);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int t0, d1, d2, d3;
        @(posedge clk);
        #1;
        t0 = cyc;
        st_data = {4{32'h04030201}};
        st_req  = 1'b1;
        wait_sig(1, 30, d1);
        wait_sig(1, 30, d2);
        wait_sig(1, 30, d3);
        st_req = 1'b0;
        n_chk++;
        if (d1 - t0 !== 18) $display("FAIL b2b_first_done: got %0d expected 18", d1 - t0);
        else n_pass++;
        n_chk++;
        if (d2 - d1 !== 19 || d3 - d2 !== 19)
            $display("FAIL b2b_period: got %0d %0d expected 19 19", d2 - d1, d3 - d2);
        else n_pass++;
        n_chk++;
        if (st_res !== {4{32'hF27B777C}}) $display("FAIL b2b_st_res: got %h expected %h", st_res, {4{32'hF27B777C}});
        else n_pass++;
        n_chk++;
        if (key_res !== 32'hF27B777C) $display("FAIL b2b_key_res_held: got %h expected F27B777C", key_res);
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (st_ack !== 1'b0 || st_done !== 1'b0) $display("FAIL b2b_stop: got ack %b done %b expected 0 0", st_ack, st_done);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_state_zero();
        test_key();
        test_arb();
        test_rnd_sweep();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
